generic_obj_rx: RTL and testbench

Receive-side deframer for the generic DPI object channel: the Python-to-SystemVerilog direction of the tagged object path. Accepts a byte stream produced by the DPI import side (one byte per handshake), hunts for start-of-frame, and extracts tag, length and payload. When the frame passes its checks it holds the complete object in a single buffer for a consumer, such as a sequence driver or APB stimulus adapter, to read.

---
 rtl/generic_obj_rx.sv | 201 ++++++++++++++++++++
 tb/tb_generic_obj_rx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_obj_rx.sv
// generic_obj_rx
//
// Receive-side deframer for the generic DPI object channel (Python to
// SystemVerilog direction). Takes one byte per handshake, hunts for the
// start-of-frame byte, then extracts tag, length and payload. A frame that
// passes its checks is held as one complete object until the consumer
// releases it.
//
// Frame: SOF, TAG, LEN, LEN payload bytes, [CHK]
//
// Optional feature macro: GENERIC_OBJ_RX_CHECKSUM_EN
//   defined   : a trailing CHK byte (XOR of TAG, LEN and payload) is expected,
//               and mismatching frames are dropped and counted.
//   undefined : no CHK byte; the frame ends after the last payload byte
//               (after LEN when LEN = 0), and only length errors are counted.
//
// Handshakes:
//   Input byte moves when s_valid & s_ready are both high on a rising PCLK
//   edge; s_data is ignored otherwise. Object side: o_valid stays high, with
//   o_tag, o_len and the buffer stable, until o_valid & o_ready is sampled
//   high; o_ready has no effect while o_valid is low.
//
// Ports:
//   PCLK, PRESETn       clock, asynchronous active-low reset
//   s_valid/s_ready     input byte handshake, s_data input byte
//   o_valid/o_ready     held-object handshake
//   o_tag, o_len        object tag and payload length (0..MAX_LEN)
//   o_rd_addr/o_rd_data combinational payload read port
//   err_cnt             saturating count of dropped frames
//   dbg_state           current FSM state (debug observation)

module generic_obj_rx #(
  parameter int         MAX_LEN = 64,
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         ERR_W   = 8
) (
  input  logic                                         PCLK,
  input  logic                                         PRESETn,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic [7:0]                                   s_data,
  output logic                                         o_valid,
  input  logic                                         o_ready,
  output logic [7:0]                                   o_tag,
  output logic [7:0]                                   o_len,
  input  logic [((MAX_LEN > 1) ? $clog2(MAX_LEN) : 1)-1:0] o_rd_addr,
  output logic [7:0]                                   o_rd_data,
  output logic [ERR_W-1:0]                             err_cnt,
  output logic [2:0]                                   dbg_state
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_TAG  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_idx;
  logic [7:0]    mem [MAX_LEN];
  logic          accept;

`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
  logic [7:0]    xor_q;
`endif

  assign accept    = s_valid & s_ready;
  assign dbg_state = state;

  // Saturating increment: a drop at all-ones leaves the count unchanged.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= ST_HUNT;
      s_ready <= 1'b1;
      o_valid <= 1'b0;
      o_tag   <= 8'd0;
      o_len   <= 8'd0;
      err_cnt <= '0;
      wr_idx  <= '0;
`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
      xor_q   <= 8'd0;
`endif
    end else begin
      case (state)
        ST_HUNT: begin
          if (accept && s_data == SOF) begin
            state <= ST_TAG;
`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
            xor_q <= 8'd0;
`endif
          end
        end

        // A SOF value here is an ordinary tag; no resynchronisation.
        ST_TAG: begin
          if (accept) begin
            o_tag <= s_data;
            state <= ST_LEN;
`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
            xor_q <= xor_q ^ s_data;
`endif
          end
        end

        ST_LEN: begin
          if (accept) begin
            if (s_data > MAX_LEN_B) begin
              err_cnt <= sat_inc(err_cnt);
              state   <= ST_HUNT;
            end else begin
              o_len  <= s_data;
              wr_idx <= '0;
`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
              xor_q  <= xor_q ^ s_data;
`endif
              if (s_data != 8'd0) begin
                state <= ST_PAY;
              end else begin
`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
                state   <= ST_CHK;
`else
                state   <= ST_HOLD;
                o_valid <= 1'b1;
                s_ready <= 1'b0;
`endif
              end
            end
          end
        end

        ST_PAY: begin
          if (accept) begin
            wr_idx <= wr_idx + 1'b1;
`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
            xor_q  <= xor_q ^ s_data;
`endif
            if (8'(wr_idx) == o_len - 8'd1) begin
`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
              state   <= ST_CHK;
`else
              state   <= ST_HOLD;
              o_valid <= 1'b1;
              s_ready <= 1'b0;
`endif
            end
          end
        end

`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            if (s_data == xor_q) begin
              state   <= ST_HOLD;
              o_valid <= 1'b1;
              s_ready <= 1'b0;
            end else begin
              err_cnt <= sat_inc(err_cnt);
              state   <= ST_HUNT;
            end
          end
        end
`endif

        // s_ready is low here, so no byte can be accepted while holding.
        ST_HOLD: begin
          if (o_ready) begin
            state   <= ST_HUNT;
            o_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end

        default: begin
          state   <= ST_HUNT;
          o_valid <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

  // Payload storage carries no reset; contents are only meaningful in HOLD.
  always_ff @(posedge PCLK) begin
    if (state == ST_PAY && accept) begin
      mem[wr_idx] <= s_data;
    end
  end

  assign o_rd_data = mem[o_rd_addr];

endmodule

// File: tb/tb_generic_obj_rx.sv
`timescale 1ns/1ps
// Bench for generic_obj_rx. A second instance with ERR_W=2 shares the same
// stimulus so the saturation behaviour is observed alongside the main one.
module tb_generic_obj_rx;

  localparam int         MAX_LEN = 64;
  localparam logic [7:0] SOF     = 8'hA5;
`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
  localparam int         CHK_BYTES = 1;
`else
  localparam int         CHK_BYTES = 0;
`endif

  typedef logic [7:0] bq_t[$];

  // ---------------- clock / reset / signals ----------------
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       o_ready = 1'b0;
  logic [5:0] o_rd_addr = 6'd0;

  logic       s_ready, o_valid;
  logic [7:0] o_tag, o_len, o_rd_data, err_cnt;
  logic [2:0] dbg_state;

  logic       sat_s_ready, sat_o_valid;
  logic [7:0] sat_o_tag, sat_o_len, sat_o_rd_data;
  logic [1:0] sat_err_cnt;
  logic [2:0] sat_dbg_state;

  always #5 PCLK = ~PCLK;

  generic_obj_rx #(.MAX_LEN(MAX_LEN), .SOF(SOF), .ERR_W(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_tag(o_tag), .o_len(o_len),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
    .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  generic_obj_rx #(.MAX_LEN(MAX_LEN), .SOF(SOF), .ERR_W(2)) dut_sat (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .s_valid(s_valid), .s_ready(sat_s_ready), .s_data(s_data),
    .o_valid(sat_o_valid), .o_ready(o_ready),
    .o_tag(sat_o_tag), .o_len(sat_o_len),
    .o_rd_addr(o_rd_addr), .o_rd_data(sat_o_rd_data),
    .err_cnt(sat_err_cnt), .dbg_state(sat_dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Collects the bytes of the frame in progress as a list and decides the
  // outcome from the list contents once it is long enough.
  bq_t        fr;
  bit         m_hold = 1'b0;
  logic [7:0] m_tag = 8'd0;
  logic [7:0] m_len = 8'd0;
  bq_t        m_pay;
  int         m_err = 0;

  task automatic model_byte(input logic [7:0] b);
    int need;
    logic [7:0] x;
    if (fr.size() == 0) begin
      if (b == SOF) fr.push_back(b);
      return;
    end
    fr.push_back(b);
    if (fr.size() == 3 && int'(fr[2]) > MAX_LEN) begin
      m_err++;
      fr = {};
      return;
    end
    if (fr.size() >= 3) begin
      need = 3 + int'(fr[2]) + CHK_BYTES;
      if (fr.size() == need) begin
        x = 8'd0;
        for (int i = 1; i < 3 + int'(fr[2]); i++) x ^= fr[i];
        if (CHK_BYTES == 1 && x != fr[need-1]) begin
          m_err++;
        end else begin
          m_tag = fr[1];
          m_len = fr[2];
          m_pay = {};
          for (int i = 0; i < int'(fr[2]); i++) m_pay.push_back(fr[3+i]);
          m_hold = 1'b1;
        end
        fr = {};
      end
    end
  endtask

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      fr = {};
      m_hold = 1'b0;
      m_tag = 8'd0;
      m_len = 8'd0;
      m_pay = {};
      m_err = 0;
    end else if (m_hold) begin
      if (o_ready) m_hold = 1'b0;
    end else if (s_valid) begin
      model_byte(s_data);
    end
  end

  // ---------------- scoreboard compare (every falling edge) ----------------
  always @(negedge PCLK) begin
    check("cyc_s_ready", s_ready, m_hold ? 0 : 1);
    check("cyc_o_valid", o_valid, m_hold ? 1 : 0);
    check("cyc_err_cnt", err_cnt, (m_err > 255) ? 255 : m_err);
    check("cyc_err_cnt_sat", sat_err_cnt, (m_err > 3) ? 3 : m_err);
    if (m_hold) begin
      check("cyc_o_tag", o_tag, m_tag);
      check("cyc_o_len", o_len, m_len);
      if (int'(o_rd_addr) < int'(m_len))
        check("cyc_rd_data", o_rd_data, m_pay[o_rd_addr]);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bq_t make_frame(input logic [7:0] tag, input bq_t pay);
    bq_t q;
    logic [7:0] x;
    q = {};
    q.push_back(SOF);
    q.push_back(tag);
    q.push_back(8'(pay.size()));
    x = tag ^ 8'(pay.size());
    foreach (pay[i]) begin
      q.push_back(pay[i]);
      x ^= pay[i];
    end
    if (CHK_BYTES == 1) q.push_back(x);
    return q;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the last byte is taken.
  task automatic send_q(input bq_t q);
    bit acc;
    int budget;
    foreach (q[i]) begin
      s_valid = 1'b1;
      s_data  = q[i];
      budget  = 0;
      acc     = 1'b0;
      while (!acc && budget < 50) begin
        @(negedge PCLK);
        acc = s_ready;
        @(posedge PCLK);
        #1;
        budget++;
      end
      if (!acc) begin
        check("send_timeout", acc, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_data  = SOF;   // idle data looks like SOF; it must be ignored
  endtask

  task automatic wait_hold(input string name);
    int n;
    n = 0;
    while (o_valid !== 1'b1 && n < 60) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    check({name, "_wait_valid"}, o_valid, 1);
  endtask

  task automatic read_at(input string name, input logic [5:0] addr, input logic [7:0] exp);
    o_rd_addr = addr;
    #1;
    check(name, o_rd_data, exp);
  endtask

  task automatic release_obj(input string name);
    o_ready = 1'b1;
    @(posedge PCLK);
    #1;
    o_ready = 1'b0;
    check({name, "_rel_valid"}, o_valid, 0);
    check({name, "_rel_ready"}, s_ready, 1);
  endtask

  // ---------------- directed tests ----------------
  localparam int BASE_ERR = CHK_BYTES;   // bad-checksum test adds one error
  bq_t p, f, f2;
  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    #1 PRESETn = 1'b0;
    @(posedge PCLK); #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_tag", o_tag, 0);
    check("rst_o_len", o_len, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Basic frame: A5 03 02 11 22 [32]
    p = '{8'h11, 8'h22};
    f = make_frame(8'h03, p);
    if (CHK_BYTES == 1) check("basic_chk_byte", f[5], 8'h32);
    send_q(f);
    check("basic_valid", o_valid, 1);
    check("basic_tag", o_tag, 8'h03);
    check("basic_len", o_len, 8'h02);
    check("basic_s_ready", s_ready, 0);
    read_at("basic_rd0", 6'd0, 8'h11);
    read_at("basic_rd1", 6'd1, 8'h22);
    release_obj("basic");

`ifdef GENERIC_OBJ_RX_CHECKSUM_EN
    // Bad checksum, then a good frame
    f = '{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33};
    send_q(f);
    repeat (3) begin @(posedge PCLK); #1; end
    check("badchk_valid", o_valid, 0);
    check("badchk_err", err_cnt, 1);
    p = '{8'h66};
    send_q(make_frame(8'h05, p));
    wait_hold("badchk_next");
    check("badchk_next_tag", o_tag, 8'h05);
    read_at("badchk_next_rd0", 6'd0, 8'h66);
    release_obj("badchk_next");
`endif

    // Length error (65 > 64), then a zero-length object
    f = '{8'hA5, 8'h07, 8'h41};
    send_q(f);
    check("lenerr_err", err_cnt, BASE_ERR + 1);
    check("lenerr_valid", o_valid, 0);
    p = {};
    send_q(make_frame(8'h07, p));
    wait_hold("len0");
    check("len0_tag", o_tag, 8'h07);
    check("len0_len", o_len, 8'h00);
    release_obj("len0");

    // Largest legal length: 64 bytes
    p = {};
    for (int i = 0; i < 64; i++) p.push_back(8'(i * 3 + 1));
    send_q(make_frame(8'h40, p));
    wait_hold("max");
    check("max_len", o_len, 8'd64);
    read_at("max_rd0", 6'd0, 8'h01);
    read_at("max_rd63", 6'd63, 8'hBE);
    for (int i = 0; i < 64; i++) begin
      o_rd_addr = 6'(i);
      @(posedge PCLK); #1;
    end
    release_obj("max");

    // Hunt through garbage, then a second frame queued behind the first
    f  = '{8'h00, 8'hFF};
    p  = '{8'h5A};
    f  = {f, make_frame(8'h01, p)};
    if (CHK_BYTES == 1) check("hunt_chk_byte", f[6], 8'h5A);
    p  = '{8'h10, 8'h20, 8'h30};
    f2 = make_frame(8'h22, p);
    f  = {f, f2};
    fork
      send_q(f);
      begin
        wait_hold("bp1");
        check("bp1_tag", o_tag, 8'h01);
        check("bp1_len", o_len, 8'h01);
        read_at("bp1_rd0", 6'd0, 8'h5A);
        repeat (3) begin
          @(posedge PCLK); #1;
          check("bp_stall_ready", s_ready, 0);
        end
        release_obj("bp1");
        wait_hold("bp2");
        check("bp2_tag", o_tag, 8'h22);
        check("bp2_len", o_len, 8'h03);
        read_at("bp2_rd2", 6'd2, 8'h30);
        release_obj("bp2");
      end
    join

    // Tag equal to SOF is just a tag
    p = '{8'h77};
    send_q(make_frame(SOF, p));
    wait_hold("sof_tag");
    check("sof_tag_tag", o_tag, 8'hA5);
    read_at("sof_tag_rd0", 6'd0, 8'h77);
    release_obj("sof_tag");

    // o_ready held high before the object exists
    o_ready = 1'b1;
    p = '{8'h99};
    send_q(make_frame(8'h44, p));
    check("early_ready_valid", o_valid, 1);
    check("early_ready_tag", o_tag, 8'h44);
    @(posedge PCLK); #1;
    check("early_ready_released", o_valid, 0);
    o_ready = 1'b0;

    // Reset in the middle of a frame
    f = '{8'hA5, 8'h03, 8'h02, 8'h11};
    send_q(f);
    #1 PRESETn = 1'b0;
    #1;
    check("midrst_s_ready", s_ready, 1);
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_tag", o_tag, 0);
    check("midrst_o_len", o_len, 0);
    check("midrst_err", err_cnt, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    p = '{8'h11, 8'h22};
    send_q(make_frame(8'h03, p));
    wait_hold("midrst_next");
    check("midrst_next_tag", o_tag, 8'h03);
    check("midrst_next_err", err_cnt, 0);
    release_obj("midrst_next");

    // Error counter saturation (ERR_W=2 instance)
    for (int k = 0; k < 5; k++) begin
      if (CHK_BYTES == 1) f = '{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33};
      else                f = '{8'hA5, 8'h07, 8'h41};
      send_q(f);
      check("sat_err_w2", sat_err_cnt, sat_exp[k]);
      check("sat_err_w8", err_cnt, k + 1);
    end

    repeat (3) @(posedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
